// File: rtl/sim_commit_monitor_if.sv
// Commit stream from the MEM/WB stage of each monitored core.
// Per-core fields are packed flat, core i at [i*W +: W].
interface sim_commit_monitor_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned XLEN      = 32
);
    logic [NUM_CORES-1:0]      commit_valid;
    logic [NUM_CORES*XLEN-1:0] commit_pc;
    logic [NUM_CORES-1:0]      commit_reg_write;
    logic [NUM_CORES*5-1:0]    commit_rd;
    logic [NUM_CORES*XLEN-1:0] commit_wdata;

    modport master (
        output commit_valid, commit_pc, commit_reg_write, commit_rd, commit_wdata
    );
    modport slave (
        input  commit_valid, commit_pc, commit_reg_write, commit_rd, commit_wdata
    );
endinterface

// File: rtl/sim_commit_monitor.sv
// Multi-core commit monitor: counts retirements, detects `j .` halts and
// produces a sticky done/pass/timeout verdict from the pass-signature register.
module sim_commit_monitor #(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned HALT_REPEAT    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned PASS_REG       = 10,
    parameter int unsigned PASS_VALUE     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    sim_commit_monitor_if.slave        commit,
    output logic                       done,
    output logic                       pass,
    output logic                       timed_out,
    output logic [NUM_CORES-1:0]       halted_mask,
    output logic [NUM_CORES-1:0]       fail_mask,
    output logic [NUM_CORES*CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0]           cycle_cnt
);
    localparam int unsigned RPT_W = $clog2(HALT_REPEAT + 1);
    localparam logic [XLEN-1:0] PASS_V = XLEN'(PASS_VALUE);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       retired_q [NUM_CORES];
    logic [CNT_W-1:0]       retired_d [NUM_CORES];
    logic [XLEN-1:0]        last_pc_q [NUM_CORES];
    logic [XLEN-1:0]        last_pc_d [NUM_CORES];
    logic [RPT_W-1:0]       repeat_q  [NUM_CORES];
    logic [RPT_W-1:0]       repeat_d  [NUM_CORES];
    logic [XLEN-1:0]        shadow_q  [NUM_CORES];
    logic [XLEN-1:0]        shadow_d  [NUM_CORES];
    logic [NUM_CORES-1:0]   halted_q, halted_d;
    logic [NUM_CORES-1:0]   fail_q, fail_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timed_out_q, timed_out_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic [XLEN-1:0]        pc_c;
    logic [RPT_W-1:0]       rpt_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            retired_q   <= '{default: '0};
            last_pc_q   <= '{default: '0};
            repeat_q    <= '{default: '0};
            shadow_q    <= '{default: ~PASS_V};
            halted_q    <= '0;
            fail_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            last_pc_q   <= last_pc_d;
            repeat_q    <= repeat_d;
            shadow_q    <= shadow_d;
            halted_q    <= halted_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            cycle_q     <= cycle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retired_d   = retired_q;
        last_pc_d   = last_pc_q;
        repeat_d    = repeat_q;
        shadow_d    = shadow_q;
        halted_d    = halted_q;
        fail_d      = fail_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        cycle_d     = cycle_q;
        pc_c        = '0;
        rpt_c       = '0;

        case (state_q)
            IDLE: begin
                retired_d   = '{default: '0};
                last_pc_d   = '{default: '0};
                repeat_d    = '{default: '0};
                shadow_d    = '{default: ~PASS_V};
                halted_d    = '0;
                fail_d      = '0;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                timed_out_d = 1'b0;
                cycle_d     = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
                for (int i = 0; i < int'(NUM_CORES); i++) begin
                    if (commit.commit_valid[i] && !halted_q[i]) begin
                        pc_c  = commit.commit_pc[i*XLEN +: XLEN];
                        // repeat_q is 0 after IDLE, so the first commit always yields 1
                        rpt_c = (pc_c == last_pc_q[i]) ? repeat_q[i] + RPT_W'(1) : RPT_W'(1);
                        if (retired_q[i] != '1) retired_d[i] = retired_q[i] + CNT_W'(1);
                        repeat_d[i]  = rpt_c;
                        last_pc_d[i] = pc_c;
                        if (rpt_c == RPT_W'(HALT_REPEAT)) halted_d[i] = 1'b1;
                        if (commit.commit_reg_write[i] && commit.commit_rd[i*5 +: 5] == 5'(PASS_REG))
                            shadow_d[i] = commit.commit_wdata[i*XLEN +: XLEN];
                    end
                end
                // All-halted takes priority over a coincident timeout
                if (&halted_d) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    for (int i = 0; i < int'(NUM_CORES); i++) fail_d[i] = (shadow_d[i] != PASS_V);
                    pass_d  = (fail_d == '0);
                end else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = TIMEOUT;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                    fail_d      = ~halted_d;
                    pass_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        retired_cnt = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) retired_cnt[i*CNT_W +: CNT_W] = retired_q[i];
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timed_out   = timed_out_q;
    assign halted_mask = halted_q;
    assign fail_mask   = fail_q;
    assign cycle_cnt   = cycle_q;
endmodule

// File: tb/tb_sim_commit_monitor.sv
// Scoreboard bench for sim_commit_monitor: stimulus queues cycle-tagged
// expected snapshots, a negedge monitor pops and compares them.
module tb_sim_commit_monitor;
    localparam int unsigned NC = 2;
    localparam int unsigned XL = 32;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    always #5 clk = ~clk;

    sim_commit_monitor_if #(.NUM_CORES(NC), .XLEN(XL)) cif ();

    logic              done, pass, timed_out;
    logic [NC-1:0]     halted_mask, fail_mask;
    logic [NC*CW-1:0]  retired_cnt;
    logic [CW-1:0]     cycle_cnt;

    sim_commit_monitor #(
        .NUM_CORES(NC), .XLEN(XL), .CNT_W(CW), .HALT_REPEAT(4),
        .TIMEOUT_CYCLES(20), .PASS_REG(10), .PASS_VALUE(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .commit(cif),
        .done(done), .pass(pass), .timed_out(timed_out),
        .halted_mask(halted_mask), .fail_mask(fail_mask),
        .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        int unsigned cyc;
        string       name;
        logic        d, p, t;
        logic [1:0]  h, f;
        logic [31:0] r0, r1, cc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s stale: checked at cycle %0d, expected at %0d", e.name, cyc, e.cyc);
            end else begin
                cmp(e.name, "done",      32'(done),        32'(e.d));
                cmp(e.name, "pass",      32'(pass),        32'(e.p));
                cmp(e.name, "timed_out", 32'(timed_out),   32'(e.t));
                cmp(e.name, "halted",    32'(halted_mask), 32'(e.h));
                cmp(e.name, "fail",      32'(fail_mask),   32'(e.f));
                cmp(e.name, "retired0",  retired_cnt[31:0],  e.r0);
                cmp(e.name, "retired1",  retired_cnt[63:32], e.r1);
                cmp(e.name, "cycle_cnt", cycle_cnt,          e.cc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic d, input logic p, input logic t,
                             input logic [1:0] h, input logic [1:0] f,
                             input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] cc);
        exp_t x;
        x.cyc = cyc; x.name = nm; x.d = d; x.p = p; x.t = t;
        x.h = h; x.f = f; x.r0 = r0; x.r1 = r1; x.cc = cc;
        exp_q.push_back(x);
    endtask

    task automatic idle_inputs();
        cif.commit_valid     = '0;
        cif.commit_pc        = '0;
        cif.commit_reg_write = '0;
        cif.commit_rd        = '0;
        cif.commit_wdata     = '0;
    endtask

    // One clock of commits; rd of 0 means no register write
    task automatic drive(input logic v0, input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] d1);
        cif.commit_valid     = {v1, v0};
        cif.commit_pc        = {pc1, pc0};
        cif.commit_reg_write = {rd1 != 5'd0, rd0 != 5'd0};
        cif.commit_rd        = {rd1, rd0};
        cif.commit_wdata     = {d1, d0};
        tick();
        idle_inputs();
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        idle_inputs();
        tick();
        tick();
        expect_st("reset", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        rst = 1'b0;

        // Both cores pass: 5 distinct PCs then 4 at 0x40
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_st("A_run", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 1, 32'h0, 0, 0);
        expect_st("A_c1", 0, 0, 0, 2'b00, 2'b00, 1, 1, 1);
        drive(1, 32'h4, 0, 0, 1, 32'h4, 0, 0);
        drive(1, 32'h8, 0, 0, 1, 32'h8, 0, 0);
        drive(1, 32'hC, 0, 0, 1, 32'hC, 11, 5);
        drive(1, 32'h10, 10, 0, 1, 32'h10, 10, 0);
        expect_st("A_c5", 0, 0, 0, 2'b00, 2'b00, 5, 5, 5);
        for (int k = 0; k < 3; k++) drive(1, 32'h40, 0, 0, 1, 32'h40, 0, 0);
        expect_st("A_c8", 0, 0, 0, 2'b00, 2'b00, 8, 8, 8);
        drive(1, 32'h40, 0, 0, 1, 32'h40, 0, 0);
        expect_st("A_done", 1, 1, 0, 2'b11, 2'b00, 9, 9, 9);
        enable = 1'b1;
        drive(1, 32'h80, 10, 7, 1, 32'h80, 10, 7);
        tick();
        enable = 1'b0;
        expect_st("A_frozen", 1, 1, 0, 2'b11, 2'b00, 9, 9, 9);

        // Core1 signature wrong; core0 post-halt write must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_st("B_rst", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        drive(1, 32'h100, 10, 0, 1, 32'h200, 10, 1);
        for (int k = 0; k < 3; k++) drive(1, 32'h100, 0, 0, 1, 32'h204, 0, 0);
        expect_st("B_c4", 0, 0, 0, 2'b01, 2'b00, 4, 4, 4);
        drive(1, 32'h100, 10, 9, 1, 32'h204, 0, 0);
        expect_st("B_done", 1, 0, 0, 2'b11, 2'b10, 4, 5, 5);

        // Core1 never halts: timeout 20 cycles after RUN entry
        restart();
        for (int k = 0; k < 4; k++)
            drive(1, 32'h300, (k == 0) ? 5'd10 : 5'd0, 0, 1, 32'h400 + 32'(4 * k), 0, 0);
        expect_st("C_c4", 0, 0, 0, 2'b01, 2'b00, 4, 4, 4);
        idle(15);
        expect_st("C_pre", 0, 0, 0, 2'b01, 2'b00, 4, 4, 19);
        idle(1);
        expect_st("C_to", 1, 0, 1, 2'b01, 2'b10, 4, 4, 20);
        enable = 1'b1;
        idle(3);
        enable = 1'b0;
        expect_st("C_frozen", 1, 0, 1, 2'b01, 2'b10, 4, 4, 20);

        // Broken repeat, post-halt commits, and halt coinciding with timeout
        restart();
        for (int k = 0; k < 3; k++) drive(1, 32'h40, (k == 0) ? 5'd10 : 5'd0, 0, 0, 0, 0, 0);
        drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
        expect_st("D_c7", 0, 0, 0, 2'b00, 2'b00, 7, 0, 7);
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
        expect_st("D_halt", 0, 0, 0, 2'b01, 2'b00, 8, 0, 8);
        for (int k = 0; k < 2; k++) drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
        expect_st("D_post", 0, 0, 0, 2'b01, 2'b00, 8, 0, 10);
        idle(6);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 32'h500, (k == 0) ? 5'd10 : 5'd0, 0);
        expect_st("E_pre", 0, 0, 0, 2'b01, 2'b00, 8, 3, 19);
        drive(0, 0, 0, 0, 1, 32'h500, 0, 0);
        expect_st("E_done", 1, 1, 0, 2'b11, 2'b00, 8, 4, 20);

        // Reset mid-RUN, then commits ignored until enable
        restart();
        for (int k = 1; k <= 3; k++) drive(1, 32'(k * 16), 0, 0, 1, 32'(k * 16), 0, 0);
        expect_st("F_c3", 0, 0, 0, 2'b00, 2'b00, 3, 3, 3);
        rst = 1'b1;
        drive(1, 32'h80, 10, 0, 1, 32'h80, 10, 0);
        rst = 1'b0;
        expect_st("F_rst", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        drive(1, 32'h90, 0, 0, 1, 32'h90, 0, 0);
        drive(1, 32'h94, 0, 0, 1, 32'h94, 0, 0);
        expect_st("F_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        enable = 1'b1;
        drive(1, 32'h98, 0, 0, 1, 32'h98, 0, 0);
        enable = 1'b0;
        expect_st("F_run", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        drive(1, 32'h9C, 0, 0, 1, 32'h9C, 0, 0);
        expect_st("F_c1", 0, 0, 0, 2'b00, 2'b00, 1, 1, 1);

        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
